// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decode stage feeding a 2-entry in-order FIFO.
// Each instruction is decoded when it is enqueued. The buffer stores the
// extended immediate, the format code, the illegal flag and a pass-through tag.
// Optional build macro: IMM_GEN_CSR_EN enables decode of the SYSTEM opcode
// (CSR immediate forms become fmt 6, register forms become I-type). When it is
// left undefined, SYSTEM decodes as unknown/illegal.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream: push = in_valid && in_ready. Downstream: pop = out_valid &&
// out_ready. in_ready depends only on the registered count, so there is no
// combinational path from out_ready to in_ready. out_* hold the head entry
// stable while out_valid && !out_ready.
module imm_gen_pipe #(
   parameter int XLEN  = 32,   // 32 or 64
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_insn,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   // Format codes presented on out_fmt
   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_Z   = 3'd6;
   localparam logic [2:0] FMT_UNK = 3'd7;

   // Major opcodes (insn[6:0])
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic signed [31:0] dec_imm32;
   logic [XLEN-1:0]    dec_imm;
   logic [2:0]         dec_fmt;
   logic               dec_ill;
   logic [6:0]         opc;

   // Classify the opcode and assemble the 32-bit immediate; the final width
   // cast sign-extends from bit 31 (U-type included) because dec_imm32 is
   // signed. The CSR zimm has bit 31 clear, so it ends up zero-extended.
   always_comb begin
      opc       = in_insn[6:0];
      dec_imm32 = '0;
      dec_fmt   = FMT_UNK;
      dec_ill   = 1'b1;
      case (opc)
         OP_REG: begin
            dec_fmt = FMT_R;
            dec_ill = 1'b0;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            dec_fmt   = FMT_I;
            dec_ill   = 1'b0;
            dec_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
         end
         OP_STORE: begin
            dec_fmt   = FMT_S;
            dec_ill   = 1'b0;
            dec_imm32 = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
         end
         OP_BRANCH: begin
            dec_fmt   = FMT_B;
            dec_ill   = 1'b0;
            dec_imm32 = {{19{in_insn[31]}}, in_insn[31], in_insn[7],
                         in_insn[30:25], in_insn[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dec_fmt   = FMT_U;
            dec_ill   = 1'b0;
            dec_imm32 = {in_insn[31:12], 12'b0};
         end
         OP_JAL: begin
            dec_fmt   = FMT_J;
            dec_ill   = 1'b0;
            dec_imm32 = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12],
                         in_insn[20], in_insn[30:21], 1'b0};
         end
         OP_IMM32: begin
            // Word-immediate ops exist only on RV64
            if (XLEN == 64) begin
               dec_fmt   = FMT_I;
               dec_ill   = 1'b0;
               dec_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
            end
         end
         OP_REG32: begin
            if (XLEN == 64) begin
               dec_fmt = FMT_R;
               dec_ill = 1'b0;
            end
         end
`ifdef IMM_GEN_CSR_EN
         OP_SYSTEM: begin
            dec_ill = 1'b0;
            if (in_insn[14]) begin
               dec_fmt   = FMT_Z;
               dec_imm32 = {27'b0, in_insn[19:15]};
            end else begin
               dec_fmt   = FMT_I;
               dec_imm32 = {{20{in_insn[31]}}, in_insn[31:20]};
            end
         end
`else
         OP_SYSTEM: begin
            dec_fmt = FMT_UNK;
            dec_ill = 1'b1;
         end
`endif
         default: begin
            dec_fmt = FMT_UNK;
            dec_ill = 1'b1;
         end
      endcase
      dec_imm = XLEN'(dec_imm32);
   end

   // ------------------------------------------------------------------
   // 2-entry FIFO control
   // ------------------------------------------------------------------
   logic [1:0] count_q, count_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       push, pop;

   logic [XLEN-1:0]  imm_q [2];
   logic [2:0]       fmt_q [2];
   logic             ill_q [2];
   logic [TAG_W-1:0] tag_q [2];

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Next count and pointers; flush wins over any push or pop this cycle
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage; cleared on reset so the head reads zero while in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            imm_q[i] <= '0;
            fmt_q[i] <= '0;
            ill_q[i] <= 1'b0;
            tag_q[i] <= '0;
         end
      end else if (push && !flush) begin
         imm_q[wr_ptr_q] <= dec_imm;
         fmt_q[wr_ptr_q] <= dec_fmt;
         ill_q[wr_ptr_q] <= dec_ill;
         tag_q[wr_ptr_q] <= in_tag;
      end
   end

   assign out_imm     = imm_q[rd_ptr_q];
   assign out_fmt     = fmt_q[rd_ptr_q];
   assign out_illegal = ill_q[rd_ptr_q];
   assign out_tag     = tag_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 instance checked through an expected
// queue, plus an XLEN=64 instance checked directly. Honours IMM_GEN_CSR_EN.
module tb_imm_gen_pipe;

   localparam int TAG_W = 6;
   localparam int W     = 32 + 3 + 1 + TAG_W;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // XLEN=32 instance
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_insn = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_imm;
   logic [2:0]       out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
   );

   // XLEN=64 instance
   logic             v_in_valid = 1'b0;
   logic             v_in_ready;
   logic [31:0]      v_in_insn = '0;
   logic [TAG_W-1:0] v_in_tag = '0;
   logic             v_out_valid;
   logic [63:0]      v_out_imm;
   logic [2:0]       v_out_fmt;
   logic             v_out_illegal;
   logic [TAG_W-1:0] v_out_tag;
   logic             v_flush = 1'b0;
   logic             v_out_ready = 1'b1;

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(v_flush),
      .in_valid(v_in_valid), .in_ready(v_in_ready), .in_insn(v_in_insn), .in_tag(v_in_tag),
      .out_valid(v_out_valid), .out_ready(v_out_ready), .out_imm(v_out_imm),
      .out_fmt(v_out_fmt), .out_illegal(v_out_illegal), .out_tag(v_out_tag)
   );

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] mk(input logic [31:0] imm, input logic [2:0] fmt,
                                       input logic ill, input logic [TAG_W-1:0] tag);
      return {imm, fmt, ill, tag};
   endfunction

   // single-bit / word check helper
   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // scoreboard: compare the head on every pop
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL sb_unexpected observed tag=%0d expected=<none>", out_tag);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            assert ({out_imm, out_fmt, out_illegal, out_tag} === e) else begin
               fails++;
               $error("FAIL sb_entry observed imm=%h fmt=%0d ill=%b tag=%0d expected imm=%h fmt=%0d ill=%b tag=%0d",
                      out_imm, out_fmt, out_illegal, out_tag,
                      e[W-1 -: 32], e[TAG_W+3 -: 3], e[TAG_W], e[TAG_W-1:0]);
            end
         end
      end
   end

   // driver: hold in_valid until accepted (bounded), then queue the expectation
   task automatic push(input logic [31:0] insn, input logic [TAG_W-1:0] tag,
                       input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_insn  = insn;
      in_tag   = tag;
      for (int n = 0; n < 20 && !ok; n++) begin
         ok = in_ready;
         @(posedge clk); #1;
      end
      chk("push_accept", 64'(ok), 64'd1);
      if (ok) exp_q.push_back(mk(imm, fmt, ill, tag));
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // XLEN=64 driver with direct checks one cycle after the push
   task automatic push64(input string name, input logic [31:0] insn, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill);
      v_in_valid = 1'b1;
      v_in_insn  = insn;
      chk({name, "_ready"}, 64'(v_in_ready), 64'd1);
      @(posedge clk); #1;
      v_in_valid = 1'b0;
      chk({name, "_valid"}, 64'(v_out_valid), 64'd1);
      chk({name, "_imm"}, v_out_imm, imm);
      chk({name, "_fmt"}, 64'(v_out_fmt), 64'(fmt));
      chk({name, "_ill"}, 64'(v_out_illegal), 64'(ill));
      @(posedge clk); #1;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_fmt", 64'(out_fmt), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
      chk("rst_out_ill", 64'(out_illegal), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // addi x1,x0,-1: one-cycle latency
      push(32'hFFF00093, 6'd1, 32'hFFFFFFFF, 3'd1, 1'b0);
      chk("lat_out_valid", 64'(out_valid), 64'd1);
      chk("lat_out_imm", 64'(out_imm), 64'hFFFFFFFF);

      // format coverage, back-to-back with out_ready high
      push(32'hFE112E23, 6'd2, 32'hFFFFFFFC, 3'd2, 1'b0); // sw x1,-4(x2)
      push(32'h00000463, 6'd3, 32'h00000008, 3'd3, 1'b0); // beq +8
      push(32'hFE000FE3, 6'd4, 32'hFFFFFFFE, 3'd3, 1'b0); // beq -2
      push(32'h123450B7, 6'd5, 32'h12345000, 3'd4, 1'b0); // lui
      push(32'h80000017, 6'd6, 32'h80000000, 3'd4, 1'b0); // auipc
      push(32'h001000EF, 6'd7, 32'h00000800, 3'd5, 1'b0); // jal +2048
      push(32'hFFDFF06F, 6'd8, 32'hFFFFFFFC, 3'd5, 1'b0); // jal -4
      push(32'h002081B3, 6'd9, 32'h00000000, 3'd0, 1'b0); // add
      push(32'h0040A083, 6'd10, 32'h00000004, 3'd1, 1'b0); // lw
      push(32'h00008067, 6'd11, 32'h00000000, 3'd1, 1'b0); // jalr
      push(32'h0010009B, 6'd12, 32'h00000000, 3'd7, 1'b1); // addiw on RV32
      push(32'h0000003B, 6'd13, 32'h00000000, 3'd7, 1'b1); // addw on RV32
      push(32'h00000000, 6'd14, 32'h00000000, 3'd7, 1'b1); // all zero
`ifdef IMM_GEN_CSR_EN
      push(32'h3402D073, 6'd15, 32'h00000005, 3'd6, 1'b0); // csrrwi
      push(32'h34029073, 6'd16, 32'h00000340, 3'd1, 1'b0); // csrrw
`else
      push(32'h3402D073, 6'd15, 32'h00000000, 3'd7, 1'b1);
      push(32'h34029073, 6'd16, 32'h00000000, 3'd7, 1'b1);
`endif
      drain();

      // backpressure: third push stalls, order preserved
      out_ready = 1'b0;
      push(32'h00100093, 6'd3, 32'h00000001, 3'd1, 1'b0);
      push(32'h00200093, 6'd4, 32'h00000002, 3'd1, 1'b0);
      in_valid = 1'b1; in_insn = 32'h00300093; in_tag = 6'd5;
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold_tag", 64'(out_tag), 64'd3);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      exp_q.push_back(mk(32'h00000003, 3'd1, 1'b0, 6'd5));
      in_valid = 1'b0;
      chk("pushpop_valid", 64'(out_valid), 64'd1);
      chk("pushpop_head", 64'(out_tag), 64'd5);
      drain();

      // flush at count 2 with in_valid high
      out_ready = 1'b0;
      push(32'h00100093, 6'd10, 32'h00000001, 3'd1, 1'b0);
      push(32'h00200093, 6'd11, 32'h00000002, 3'd1, 1'b0);
      in_valid = 1'b1; in_insn = 32'h00300093; in_tag = 6'd12; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("flush2_out_valid", 64'(out_valid), 64'd0);
      chk("flush2_in_ready", 64'(in_ready), 64'd1);

      // flush at count 1 drops a same-cycle accepted push
      push(32'h00100093, 6'd20, 32'h00000001, 3'd1, 1'b0);
      in_valid = 1'b1; in_insn = 32'h00500093; in_tag = 6'd21; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("flush1_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("flush1_dropped", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      push(32'hFFF00093, 6'd22, 32'hFFFFFFFF, 3'd1, 1'b0);
      drain();

      // XLEN=64 instance
      push64("x64_lui", 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      push64("x64_addiw", 32'h0010009B, 64'h0000000000000001, 3'd1, 1'b0);
      push64("x64_addw", 32'h0000003B, 64'h0, 3'd0, 1'b0);
      push64("x64_addi", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      push64("x64_jal", 32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      push(32'h00000000, 6'd30, 32'h00000000, 3'd7, 1'b1);
      chk("zero_fmt", 64'(out_fmt), 64'd7);
      chk("zero_ill", 64'(out_illegal), 64'd1);
      push(32'h00100093, 6'd31, 32'h00000001, 3'd1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_out_tag", 64'(out_tag), 64'd0);
      chk("arst_out_imm", 64'(out_imm), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("arst_no_reappear", 64'(out_valid), 64'd0);
      push(32'h00000463, 6'd40, 32'h00000008, 3'd3, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
